pll_underclock_ctrl: RTL
========================

PLL_UNDERCLOCK_CTRL -- requirements
Module: pll_underclock_ctrl

Interface
REQ-001 Parameter FRAC_NATIVE, 32'd3639383488, K-fraction word for native speed.
REQ-002 Parameter FRAC_UNDER, 32'd3262113561, K-fraction word for the 60Hz-adjust underclock.
REQ-003 Parameter GAP_CYCLES, 3, idle cycles between consecutive management writes (range 1-15).
REQ-004 Parameter LOCK_TIMEOUT, 20'd500000, maximum lock-wait cycles (lock-wait build only).
REQ-005 clk_sys  in  1  management clock, all logic on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 req_underclock  in  1  requested mode, asynchronous level: 1 = underclock, 0 = native.
REQ-008 mgmt_waitrequest  in  1  reconfiguration-controller stall.
REQ-009 mgmt_write  out  1  Avalon-MM write strobe.
REQ-010 mgmt_address  out  6  register address.
REQ-011 mgmt_writedata  out  32  register data.
REQ-012 pll_locked  in  1  PLL lock indicator, asynchronous.
REQ-013 busy  out  1  high from sequence start until DONE is left.
REQ-014 applied  out  1  mode currently programmed into the PLL.
REQ-015 done  out  1  one-cycle pulse at the end of each sequence.
REQ-016 lock_err  out  1  sticky lock-timeout flag, cleared at the next sequence start.

Function
REQ-017 req_underclock passes through a 2-flop synchronizer; a third flop holds the previous synced sample.
REQ-018 The request is stable when the synced and previous samples are equal.
REQ-019 In IDLE, a stable request different from applied starts a sequence next cycle; the target value is latched at that point.
REQ-020 State machine states: IDLE, WR_MODE, GAP1, WR_FRAC, GAP2, WR_START, LOCK_WAIT, DONE.
REQ-021 WR_MODE writes address 0, data 0 (waitrequest mode).
REQ-022 WR_FRAC writes address 7 with FRAC_UNDER if target = 1, else FRAC_NATIVE.
REQ-023 WR_START writes address 2, data 0.
REQ-024 Write handshake: mgmt_write, address and data stay constant from first assertion until a cycle with mgmt_waitrequest low, which completes the transfer; mgmt_write deasserts the next cycle.
REQ-025 GAP1 and GAP2 each last exactly GAP_CYCLES cycles, with mgmt_write low.
REQ-026 A write is never started while a previous write is pending.
REQ-027 On DONE: applied is set to target, done pulses for one cycle, and the FSM returns to IDLE.
REQ-028 Request changes during a sequence are ignored until IDLE; the FSM then re-evaluates and may start a new sequence the following cycle.
REQ-029 A request toggling faster than one synced sample is never stable and starts no sequence.
REQ-030 mgmt_address and mgmt_writedata are 0 whenever mgmt_write is low.

Reset
REQ-031 Asynchronous reset forces IDLE; mgmt_write=0, mgmt_address=0, mgmt_writedata=0, busy=0, applied=0, done=0, lock_err=0; synchronizer and counters are cleared.
REQ-032 Reset asserted mid-write abandons the transfer immediately; after release, a stable request of 1 starts a fresh sequence from WR_MODE.

Configuration
REQ-033 Macro PLL_UNDERCLOCK_LOCK_WAIT_EN: when defined, WR_START is followed by LOCK_WAIT.
REQ-034 LOCK_WAIT waits 16 cycles, then waits for synced pll_locked = 1.
REQ-035 If pll_locked is not high within LOCK_TIMEOUT cycles, lock_err is set and the FSM enters DONE anyway.
REQ-036 When PLL_UNDERCLOCK_LOCK_WAIT_EN is undefined: WR_START goes directly to DONE, pll_locked is unused, lock_err is tied to 0, and no LOCK_WAIT logic is built.

Structure
REQ-037 Shared package pll_ctrl_pkg holds the FSM state enum and the register-address constants (REG_MODE=0, REG_START=2, REG_KFRAC=7).
REQ-038 One sub-module, mgmt_avalon_writer, holds the single-write handshake of REQ-024 (start/done handshake to the FSM).

Verification
REQ-039 Scenario 1: req 0->1 held, waitrequest=0.
- Required: writes (0,0), (7,3262113561), (2,0) in that order, each separated by exactly 3 idle cycles.
- Then: done pulses once, applied=1.
REQ-040 Scenario 2: waitrequest held high 5 cycles during the address-7 write.
- Required: write, address and data are held stable for 6 cycles, then a single completion.
REQ-041 Scenario 3: req toggled 1->0 during GAP1.
- Required: the sequence completes with 3262113561 and applied=1.
- Then: a second sequence writes 3639383488, ending with applied=0.
REQ-042 Scenario 4: reset asserted during the address-7 write, req=1.
- Required: mgmt_write=0 immediately.
- After release: a complete three-write sequence, then applied=1.
REQ-043 Scenario 5: 1-cycle req glitch.
- Required: no mgmt_write ever asserted, busy stays 0.
REQ-044 Scenario 6 (PLL_UNDERCLOCK_LOCK_WAIT_EN defined, LOCK_TIMEOUT=100): pll_locked held 0.
- Required: lock_err=1 after 116 cycles, then done pulses.
- Next sequence start: lock_err clears.

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL underclock controller: FSM state encoding
// and the reconfiguration-controller register map.
package pll_ctrl_pkg;

    localparam int ADDR_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WR_MODE   = 3'd1,
        ST_GAP1      = 3'd2,
        ST_WR_FRAC   = 3'd3,
        ST_GAP2      = 3'd4,
        ST_WR_START  = 3'd5,
        ST_LOCK_WAIT = 3'd6,
        ST_DONE      = 3'd7
    } ctrl_state_t;

    localparam logic [ADDR_W-1:0] REG_MODE  = 6'd0;
    localparam logic [ADDR_W-1:0] REG_START = 6'd2;
    localparam logic [ADDR_W-1:0] REG_KFRAC = 6'd7;

endpackage

// File: rtl/mgmt_avalon_writer.sv
// Single Avalon-MM write: accepts a start request when idle and holds the
// strobe, address and data until the slave drops waitrequest.
module mgmt_avalon_writer
    import pll_ctrl_pkg::*;
(
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       data,
    input  logic              mgmt_waitrequest,
    output logic              mgmt_write,
    output logic [ADDR_W-1:0] mgmt_address,
    output logic [31:0]       mgmt_writedata,
    output logic              wr_done
);

    // Completion is the cycle the slave accepts; the FSM advances on it.
    assign wr_done = mgmt_write & ~mgmt_waitrequest;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            mgmt_write     <= 1'b0;
            mgmt_address   <= '0;
            mgmt_writedata <= '0;
        end else if (!mgmt_write) begin
            if (start) begin
                mgmt_write     <= 1'b1;
                mgmt_address   <= addr;
                mgmt_writedata <= data;
            end
        end else if (!mgmt_waitrequest) begin
            mgmt_write     <= 1'b0;
            mgmt_address   <= '0;
            mgmt_writedata <= '0;
        end
    end

endmodule

// File: rtl/pll_underclock_ctrl.sv
// Reprograms the PLL K-fraction for native or underclock mode via three
// management writes. Define PLL_UNDERCLOCK_LOCK_WAIT_EN to wait for PLL lock.
module pll_underclock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter logic [31:0] FRAC_NATIVE  = 32'd3639383488,
    parameter logic [31:0] FRAC_UNDER   = 32'd3262113561,
    parameter int          GAP_CYCLES   = 3,
    parameter logic [19:0] LOCK_TIMEOUT = 20'd500000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        req_underclock,
    input  logic        mgmt_waitrequest,
    output logic        mgmt_write,
    output logic [5:0]  mgmt_address,
    output logic [31:0] mgmt_writedata,
    input  logic        pll_locked,
    output logic        busy,
    output logic        applied,
    output logic        done,
    output logic        lock_err
);

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    ctrl_state_t       state;
    logic              req_s1, req_s2, req_prev;
    logic              req_stable, start_seq;
    logic              target;
    logic [3:0]        gap_cnt;
    logic              wr_start, wr_done;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            req_s1   <= 1'b0;
            req_s2   <= 1'b0;
            req_prev <= 1'b0;
        end else begin
            req_s1   <= req_underclock;
            req_s2   <= req_s1;
            req_prev <= req_s2;
        end
    end

    assign req_stable = (req_s2 == req_prev);
    assign start_seq  = (state == ST_IDLE) && req_stable && (req_s2 != applied);
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);

`ifdef PLL_UNDERCLOCK_LOCK_WAIT_EN
    localparam logic [20:0] LOCK_SETTLE = 21'd16;
    localparam logic [20:0] LOCK_LAST   = LOCK_SETTLE + 21'(LOCK_TIMEOUT) - 21'd1;

    logic        lock_s1, lock_s2;
    logic [20:0] lock_cnt;
    logic        lock_expired, lock_exit;

    assign lock_expired = (lock_cnt == LOCK_LAST);
    assign lock_exit    = (lock_cnt >= LOCK_SETTLE) && (lock_s2 || lock_expired);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            lock_s1  <= 1'b0;
            lock_s2  <= 1'b0;
            lock_cnt <= '0;
            lock_err <= 1'b0;
        end else begin
            lock_s1 <= pll_locked;
            lock_s2 <= lock_s1;
            if (state != ST_LOCK_WAIT)
                lock_cnt <= '0;
            else if (!lock_exit)
                lock_cnt <= lock_cnt + 21'd1;
            if (start_seq)
                lock_err <= 1'b0;
            else if (state == ST_LOCK_WAIT && lock_expired && !lock_s2)
                lock_err <= 1'b1;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = pll_locked ^ LOCK_TIMEOUT[0];
    assign lock_err    = 1'b0;
`endif

    // Writes are launched on the cycle the FSM moves into the write state, so
    // each gap is exactly GAP_CYCLES idle bus cycles.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wr_start = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        case (state)
            ST_IDLE: if (start_seq) begin
                wr_start = 1'b1;
                wr_addr  = REG_MODE;
            end
            ST_GAP1: if (gap_cnt == 4'd0) begin
                wr_start = 1'b1;
                wr_addr  = REG_KFRAC;
                wr_data  = target ? FRAC_UNDER : FRAC_NATIVE;
            end
            ST_GAP2: if (gap_cnt == 4'd0) begin
                wr_start = 1'b1;
                wr_addr  = REG_START;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            target  <= 1'b0;
            applied <= 1'b0;
            gap_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start_seq) begin
                    state  <= ST_WR_MODE;
                    target <= req_s2;
                end
                ST_WR_MODE: if (wr_done) begin
                    state   <= ST_GAP1;
                    gap_cnt <= GAP_LAST;
                end
                ST_GAP1: if (gap_cnt == 4'd0) state <= ST_WR_FRAC;
                         else gap_cnt <= gap_cnt - 4'd1;
                ST_WR_FRAC: if (wr_done) begin
                    state   <= ST_GAP2;
                    gap_cnt <= GAP_LAST;
                end
                ST_GAP2: if (gap_cnt == 4'd0) state <= ST_WR_START;
                         else gap_cnt <= gap_cnt - 4'd1;
                ST_WR_START: if (wr_done) begin
`ifdef PLL_UNDERCLOCK_LOCK_WAIT_EN
                    state <= ST_LOCK_WAIT;
`else
                    state <= ST_DONE;
`endif
                end
`ifdef PLL_UNDERCLOCK_LOCK_WAIT_EN
                ST_LOCK_WAIT: if (lock_exit) state <= ST_DONE;
`endif
                ST_DONE: begin
                    applied <= target;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    mgmt_avalon_writer u_writer (
        .clk_sys          (clk_sys),
        .reset            (reset),
        .start            (wr_start),
        .addr             (wr_addr),
        .data             (wr_data),
        .mgmt_waitrequest (mgmt_waitrequest),
        .mgmt_write       (mgmt_write),
        .mgmt_address     (mgmt_address),
        .mgmt_writedata   (mgmt_writedata),
        .wr_done          (wr_done)
    );

endmodule
